// File: rtl/memref_responder.sv
// rtl/memref_responder.sv - preloadable word memory serving a kernel's read/write requests
//
// Purpose: a LOAD phase fills the memory from a valid/ready preload stream
// (addresses 0..SIZE-1 in order), a single START cycle pulses tstart, and a
// terminal RUN phase services one read and one write per cycle. Reads return
// through a RD_LATENCY-deep registered pipeline. Out-of-range accesses set a
// sticky addr_err; such reads return zero and such writes are dropped.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ld_valid/ld_ready   preload beat handshake, ld_data = preload word
//   tstart              one-cycle kernel start pulse
//   rd_en, rd_addr      kernel read request
//   rd_data, rd_valid   read response (rd_data holds when rd_valid is low)
//   wr_en, wr_addr,
//   wr_data             kernel write request
//   addr_err            sticky out-of-range access flag
//
// Build option: define MEMREF_WR_BYPASS_EN to make a same-cycle, same-address,
// in-range read and write return the write data (write-first). Undefined, such
// a collision is read-first.

module memref_responder #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 64,
  parameter int ADDR_W     = $clog2(SIZE),
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              tstart,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              addr_err
);

  // One extra bit so SIZE itself is representable when SIZE is a power of two.
  localparam logic [ADDR_W:0] SIZE_EXT = (ADDR_W+1)'(SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  typedef enum logic [1:0] {LOAD, START, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ld_ptr;
  logic [WIDTH-1:0]  mem [SIZE];

  logic              ld_fire, ld_last, run;
  logic              rd_fire, wr_fire, rd_in_range, wr_in_range;
  logic [WIDTH-1:0]  rd_word;

  logic [RD_LATENCY-1:0] vpipe;
  logic [WIDTH-1:0]      dpipe [RD_LATENCY];

  assign ld_fire     = ld_valid && ld_ready;
  assign ld_last     = (ld_ptr == LAST_ADDR);
  assign rd_in_range = ({1'b0, rd_addr} < SIZE_EXT);
  assign wr_in_range = ({1'b0, wr_addr} < SIZE_EXT);
  assign rd_fire     = run && rd_en;
  assign wr_fire     = run && wr_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (ld_fire && ld_last) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs decoded from state. ld_ready is gated by rst_n so it is low while
  // reset is held and rises as soon as reset is released.
  always_comb begin
    ld_ready = (state == LOAD) && rst_n;
    tstart   = (state == START);
    run      = (state == RUN);
  end

  // Load pointer stops on the last address instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ld_ptr <= '0;
    else if (ld_fire && !ld_last) ld_ptr <= ld_ptr + ADDR_W'(1);
  end

  // Storage is deliberately not reset. Preload and kernel writes never overlap
  // because they belong to different states.
  always_ff @(posedge clk) begin
    if (ld_fire)                     mem[ld_ptr]  <= ld_data;
    else if (wr_fire && wr_in_range) mem[wr_addr] <= wr_data;
  end

  // Read word captured at the request edge; the array read sees pre-write data.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[rd_addr];
`ifdef MEMREF_WR_BYPASS_EN
    if (rd_in_range && wr_fire && (wr_addr == rd_addr)) rd_word = wr_data;
`endif
  end

  // Read pipeline: stage 0 captures at the request edge, the last stage is the
  // output register. Data stages only load on a valid beat so rd_data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dpipe[i] <= '0;
    end else begin
      vpipe[0] <= rd_fire;
      if (rd_fire) dpipe[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        if (vpipe[i-1]) dpipe[i] <= dpipe[i-1];
      end
    end
  end

  assign rd_valid = vpipe[RD_LATENCY-1];
  assign rd_data  = dpipe[RD_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      addr_err <= 1'b0;
    else if ((rd_fire && !rd_in_range) || (wr_fire && !wr_in_range))
      addr_err <= 1'b1;
  end

endmodule

// File: doc/memref_responder.md
MEMREF_RESPONDER -- requirements
Module: memref_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter SIZE, default 64, number of words (2..1024).
REQ-003 SHALL have parameter ADDR_W, default $clog2(SIZE), address width.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles (1..4).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port ld_valid  input  1  preload beat valid.
REQ-009 SHALL have port ld_ready  output  1  preload beat accepted when high with ld_valid.
REQ-010 SHALL have port ld_data  input  WIDTH  preload word.
REQ-011 SHALL have port tstart  output  1  one-cycle kernel start pulse.
REQ-012 SHALL have port rd_en  input  1  kernel read request.
REQ-013 SHALL have port rd_addr  input  ADDR_W  kernel read address.
REQ-014 SHALL have port rd_data  output  WIDTH  read response data.
REQ-015 SHALL have port rd_valid  output  1  read response valid.
REQ-016 SHALL have port wr_en  input  1  kernel write request.
REQ-017 SHALL have port wr_addr  input  ADDR_W  kernel write address.
REQ-018 SHALL have port wr_data  input  WIDTH  kernel write data.
REQ-019 SHALL have port addr_err  output  1  sticky out-of-range access flag.

Function
REQ-020 SHALL implement states LOAD, START, RUN; reset enters LOAD.
REQ-021 In LOAD, ld_ready SHALL be 1; each ld_valid&ld_ready beat writes ld_data to the load pointer, which starts at 0 and increments by 1 per beat.
REQ-022 The beat that writes address SIZE-1 SHALL move LOAD->START; the pointer SHALL NOT wrap, and ld_ready SHALL be 0 outside LOAD.
REQ-023 START SHALL last exactly one cycle with tstart=1, then move to RUN; tstart SHALL be 0 in every other cycle.
REQ-024 RUN SHALL be terminal until reset.
REQ-025 rd_en/wr_en SHALL be ignored outside RUN: no response, no write, no addr_err.
REQ-026 In RUN, rd_en sampled at edge N SHALL produce rd_valid=1 and rd_data=mem[rd_addr] on the cycle after edge N+RD_LATENCY-1, i.e. registered outputs, RD_LATENCY cycles after the request.
REQ-027 Reads SHALL be fully pipelined, one per cycle, with no backpressure.
REQ-028 When no response is due, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-029 In RUN, wr_en SHALL write wr_data to mem[wr_addr] at the sampling edge.
REQ-030 A read and a write in the same cycle SHALL both be serviced.
REQ-031 An address >= SIZE SHALL set addr_err, which stays set until reset.
REQ-032 A read to an address >= SIZE SHALL still return rd_valid, with rd_data=0.
REQ-033 A write to an address >= SIZE SHALL be dropped.
REQ-034 Same-address read and write in one cycle SHALL return the pre-write data (read-first), unless REQ-041 applies.

Reset
REQ-035 During reset, outputs SHALL be ld_ready=0, tstart=0, rd_valid=0, rd_data=0, addr_err=0.
REQ-036 ld_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-037 Reset SHALL clear the read pipeline, load pointer and state asynchronously.
REQ-038 Memory contents SHALL NOT be reset.
REQ-039 Reset mid-LOAD or mid-RUN SHALL discard in-flight reads and restart LOAD at address 0.

Configuration
REQ-040 SHALL support macro MEMREF_WR_BYPASS_EN.
REQ-041 With MEMREF_WR_BYPASS_EN defined, a same-cycle same-address in-range read and write SHALL return wr_data (write-first).
REQ-042 Without MEMREF_WR_BYPASS_EN, a same-cycle same-address read and write SHALL be read-first.
REQ-043 The macro SHALL NOT affect different-address accesses or latency.

Verification
REQ-044 SHALL cover preload: 64 beats of values 1..64 with ld_valid gaps -> ld_ready drops after beat 64; tstart is high exactly one cycle, one cycle after the last beat.
REQ-045 SHALL cover pipelined reads: RD_LATENCY=1, reads of addresses 0,1,2 on consecutive cycles -> rd_valid high for 3 cycles with rd_data 1,2,3, each 1 cycle after its request.
REQ-046 SHALL cover read latency 3: RD_LATENCY=3, a read of address 5 -> rd_data=6 with rd_valid exactly 3 cycles later.
REQ-047 SHALL cover a collision: write 0xAA to address 7 with a read of address 7 in the same cycle -> rd_data=8 without the macro, 0xAA with it; a read of address 7 the next cycle returns 0xAA.
REQ-048 SHALL cover out-of-range access: SIZE=48, read of address 50 -> rd_valid=1, rd_data=0, addr_err=1; a write to 50 leaves all memory unchanged.
REQ-049 SHALL cover reset mid-run: rst_n low during an outstanding read -> rd_valid never pulses for that read, ld_ready=1 after release, and the next ld beat writes address 0.
